// File: rtl/zx81_tape_dma.sv
// ZX80/ZX81 fast-load sequencer: spots the ROM LOAD entry on M1, overlays a short loop patch
// and streams the tape buffer into main RAM. Define TAPE_DMA_XSUM_EN to add the xsum output.
module zx81_tape_dma #(
  parameter logic [15:0] ZX81_ENTRY = 16'h0347,
  parameter logic [15:0] ZX81_EXIT  = 16'h03C3,
  parameter logic [15:0] ZX80_ENTRY = 16'h0207,
  parameter logic [15:0] ZX80_EXIT  = 16'h024D,
  parameter int          P_OFFSET   = 9
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_cpu_p,
  input  logic        zx81,
  input  logic        nM1,
  input  logic [15:0] addr,
  input  logic [13:0] tape_size,
  input  logic        tape_type,
  output logic [13:0] tape_addr,
  input  logic [7:0]  tape_byte,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  output logic        dma_active,
  output logic        patch_sel,
  output logic [7:0]  patch_byte,
  output logic        load_done
`ifdef TAPE_DMA_XSUM_EN
  ,
  output logic [7:0]  xsum
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  state_t      state_reg;
  logic        old_nm1_reg;
  logic [13:0] index_reg;

  logic [15:0] entry_addr;
  logic [15:0] exit_addr;
  logic        m1_edge;
  logic        is_entry;
  logic        is_exit;
  logic [13:0] wr_offset;
  logic [13:0] wr_index;
  logic        in_window;
  logic [2:0]  patch_ofs;

  assign entry_addr = zx81 ? ZX81_ENTRY : ZX80_ENTRY;
  assign exit_addr  = zx81 ? ZX81_EXIT  : ZX80_EXIT;
  assign m1_edge    = old_nm1_reg & ~nM1;
  assign is_entry   = (addr == entry_addr);
  assign is_exit    = (addr < entry_addr) || (addr >= exit_addr);
  assign wr_offset  = tape_type ? 14'(P_OFFSET) : 14'd0;
  // RAM offset wraps inside the 16K window above 0x4000
  assign wr_index   = index_reg + wr_offset;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= IDLE;
      old_nm1_reg <= 1'b1;
      index_reg   <= 14'd0;
      tape_addr   <= 14'd0;
      ram_addr    <= 16'd0;
      ram_data    <= 8'd0;
      ram_we      <= 1'b0;
      dma_active  <= 1'b0;
      load_done   <= 1'b0;
`ifdef TAPE_DMA_XSUM_EN
      xsum        <= 8'd0;
`endif
    end else begin
      old_nm1_reg <= nM1;
      ram_we      <= 1'b0;
      if (m1_edge && is_exit) begin
        state_reg  <= IDLE;
        index_reg  <= 14'd0;
        tape_addr  <= 14'd0;
        dma_active <= 1'b0;
        load_done  <= 1'b0;
`ifdef TAPE_DMA_XSUM_EN
        xsum       <= 8'd0;
`endif
      end else if (m1_edge && is_entry) begin
        // Entry fetch (re)starts the load; no write is issued in this clock
        state_reg  <= FETCH;
        index_reg  <= 14'd0;
        tape_addr  <= 14'd0;
        dma_active <= 1'b1;
        load_done  <= 1'b0;
`ifdef TAPE_DMA_XSUM_EN
        xsum       <= 8'd0;
`endif
      end else begin
        case (state_reg)
          FETCH: begin
            if (tape_size == 14'd0) begin
              state_reg <= DONE;
              load_done <= 1'b1;
            end else begin
              state_reg <= STREAM;
            end
          end
          STREAM: begin
            if (index_reg >= tape_size) begin
              state_reg <= DONE;
              load_done <= 1'b1;
            end else if (ce_cpu_p) begin
              ram_we    <= 1'b1;
              ram_data  <= tape_byte;
              ram_addr  <= {2'b01, wr_index};
              index_reg <= index_reg + 14'd1;
              tape_addr <= index_reg + 14'd1;
`ifdef TAPE_DMA_XSUM_EN
              xsum      <= xsum ^ tape_byte;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_window = (addr >= entry_addr) && (addr <= entry_addr + 16'd6);
  assign patch_sel = dma_active & in_window;
  assign patch_ofs = addr[2:0] - entry_addr[2:0];

  // xor a; nop|scf; jr nc,-3; jp back into the ROM loader
  always_comb begin
    patch_byte = 8'h00;
    if (patch_sel) begin
      case (patch_ofs)
        3'd0:    patch_byte = 8'hAF;
        3'd1:    patch_byte = load_done ? 8'h37 : 8'h00;
        3'd2:    patch_byte = 8'h30;
        3'd3:    patch_byte = 8'hFD;
        3'd4:    patch_byte = 8'hC3;
        3'd5:    patch_byte = zx81 ? 8'h07 : 8'h03;
        3'd6:    patch_byte = 8'h02;
        default: patch_byte = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_zx81_tape_dma.sv
// Directed bench for zx81_tape_dma: tape buffer model, CPU M1 fetches and a RAM write log.
module tb_zx81_tape_dma;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_cpu_p = 1'b0;
  logic        zx81;
  logic        nM1;
  logic [15:0] addr;
  logic [13:0] tape_size;
  logic        tape_type;
  logic [13:0] tape_addr;
  logic [7:0]  tape_byte = 8'h00;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        dma_active;
  logic        patch_sel;
  logic [7:0]  patch_byte;
  logic        load_done;
`ifdef TAPE_DMA_XSUM_EN
  logic [7:0]  xsum;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  tape_mem [0:15];
  logic [15:0] wr_addr_log [0:255];
  logic [7:0]  wr_data_log [0:255];
  int          wr_count = 0;
  logic [1:0]  ce_cnt = 2'd0;

  zx81_tape_dma dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_cpu_p   (ce_cpu_p),
    .zx81       (zx81),
    .nM1        (nM1),
    .addr       (addr),
    .tape_size  (tape_size),
    .tape_type  (tape_type),
    .tape_addr  (tape_addr),
    .tape_byte  (tape_byte),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .dma_active (dma_active),
    .patch_sel  (patch_sel),
    .patch_byte (patch_byte),
    .load_done  (load_done)
`ifdef TAPE_DMA_XSUM_EN
    ,
    .xsum       (xsum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Tape buffer: registered read, one clock latency
  always @(posedge clk_sys) tape_byte <= tape_mem[tape_addr[3:0]];

  // CPU clock enable: one pulse every 4 clocks
  always @(negedge clk_sys) begin
    ce_cnt   = ce_cnt + 2'd1;
    ce_cpu_p = (ce_cnt == 2'd0);
  end

  always @(posedge clk_sys) begin
    #1;
    if (ram_we) begin
      wr_addr_log[wr_count % 256] = ram_addr;
      wr_data_log[wr_count % 256] = ram_data;
      $display("[TB] write %0d: ram[%04h] <= %02h", wr_count, ram_addr, ram_data);
      wr_count = wr_count + 1;
    end
  end

  task automatic do_fetch(input logic [15:0] a);
    @(negedge clk_sys);
    addr = a;
    nM1  = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    nM1 = 1'b1;
    $display("[TB] M1 fetch %04h: dma_active=%0b load_done=%0b", a, dma_active, load_done);
  endtask

  task automatic test_reset;
    reset = 1'b1; nM1 = 1'b1; addr = 16'h0000; zx81 = 1'b1;
    tape_size = 14'd0; tape_type = 1'b0;
    repeat (3) @(negedge clk_sys);
    tests_run++;
    if ({ram_we, dma_active, patch_sel, load_done} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got we/act/sel/done=%b want 0000", {ram_we, dma_active, patch_sel, load_done});
    end
    tests_run++;
    if ({ram_addr, ram_data, patch_byte, tape_addr} !== 46'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_buses: ram_addr=%h ram_data=%h patch=%h tape_addr=%h want all 0", ram_addr, ram_data, patch_byte, tape_addr);
    end
`ifdef TAPE_DMA_XSUM_EN
    tests_run++;
    if (xsum !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_xsum: got %h want 00", xsum);
    end
`endif
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_zx81_p;
    logic [15:0] exp_a [4];
    logic [7:0]  exp_d [4];
    int base;
    exp_a = '{16'h4009, 16'h400A, 16'h400B, 16'h400C};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) tape_mem[i] = exp_d[i];
    zx81 = 1'b1; tape_size = 14'd4; tape_type = 1'b1;
    base = wr_count;
    do_fetch(16'h0347);
    for (int k = 0; k < 300 && !load_done; k++) @(negedge clk_sys);
    tests_run++;
    if (load_done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zx81_done: load_done=%b want 1 (timeout)", load_done);
    end
    tests_run++;
    if (wr_count - base !== 4) begin
      tests_failed++;
      $display("[TB] FAIL zx81_count: got %0d writes want 4", wr_count - base);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (wr_addr_log[base + i] !== exp_a[i] || wr_data_log[base + i] !== exp_d[i]) begin
        tests_failed++;
        $display("[TB] FAIL zx81_write%0d: got %h<=%h want %h<=%h", i, wr_addr_log[base + i], wr_data_log[base + i], exp_a[i], exp_d[i]);
      end
    end
    addr = 16'h0348; #1;
    tests_run++;
    if (patch_sel !== 1'b1 || patch_byte !== 8'h37) begin
      tests_failed++;
      $display("[TB] FAIL zx81_patch1: sel=%b byte=%h want 1/37", patch_sel, patch_byte);
    end
    addr = 16'h034C; #1;
    tests_run++;
    if (patch_byte !== 8'h07) begin
      tests_failed++;
      $display("[TB] FAIL zx81_patch5: got %h want 07", patch_byte);
    end
    do_fetch(16'h03C3);
    tests_run++;
    if ({dma_active, load_done, patch_sel} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL zx81_exit: act/done/sel=%b want 000", {dma_active, load_done, patch_sel});
    end
    base = wr_count;
    repeat (20) @(negedge clk_sys);
    tests_run++;
    if (wr_count !== base) begin
      tests_failed++;
      $display("[TB] FAIL zx81_no_we_after_exit: got %0d extra writes want 0", wr_count - base);
    end
  endtask

  task automatic test_zx80_o;
    int base;
    tape_mem[0] = 8'hA5; tape_mem[1] = 8'h5A;
    zx81 = 1'b0; tape_size = 14'd2; tape_type = 1'b0;
    base = wr_count;
    do_fetch(16'h0207);
    for (int k = 0; k < 300 && !load_done; k++) @(negedge clk_sys);
    tests_run++;
    if (wr_count - base !== 2 || wr_addr_log[base] !== 16'h4000 || wr_addr_log[base + 1] !== 16'h4001
        || wr_data_log[base] !== 8'hA5 || wr_data_log[base + 1] !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL zx80_writes: n=%0d %h<=%h %h<=%h want 2 4000<=a5 4001<=5a", wr_count - base,
               wr_addr_log[base], wr_data_log[base], wr_addr_log[base + 1], wr_data_log[base + 1]);
    end
    addr = 16'h020C; #1;
    tests_run++;
    if (patch_byte !== 8'h03) begin
      tests_failed++;
      $display("[TB] FAIL zx80_patch5: got %h want 03", patch_byte);
    end
    addr = 16'h0207; #1;
    tests_run++;
    if (patch_byte !== 8'hAF) begin
      tests_failed++;
      $display("[TB] FAIL zx80_patch0: got %h want af", patch_byte);
    end
    do_fetch(16'h024D);
    tests_run++;
    if (dma_active !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zx80_exit: dma_active=%b want 0", dma_active);
    end
  endtask

  task automatic test_empty;
    int base;
    zx81 = 1'b1; tape_size = 14'd0; tape_type = 1'b1;
    base = wr_count;
    do_fetch(16'h0347);
    tests_run++;
    if (load_done !== 1'b1 || dma_active !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL empty_done: done=%b act=%b want 1/1 within 2 clk", load_done, dma_active);
    end
    addr = 16'h0348; #1;
    tests_run++;
    if (patch_byte !== 8'h37) begin
      tests_failed++;
      $display("[TB] FAIL empty_patch1: got %h want 37", patch_byte);
    end
    repeat (10) @(negedge clk_sys);
    tests_run++;
    if (wr_count !== base) begin
      tests_failed++;
      $display("[TB] FAIL empty_no_we: got %0d writes want 0", wr_count - base);
    end
    do_fetch(16'h0000);
  endtask

  task automatic test_reset_mid;
    int base;
    for (int i = 0; i < 10; i++) tape_mem[i] = 8'h80 + 8'(i);
    zx81 = 1'b1; tape_size = 14'd10; tape_type = 1'b1;
    base = wr_count;
    do_fetch(16'h0347);
    for (int k = 0; k < 300 && wr_count < base + 3; k++) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    tests_run++;
    if ({ram_we, dma_active, patch_sel, load_done} !== 4'b0000 || ram_addr !== 16'h0000 || tape_addr !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: we/act/sel/done=%b ram_addr=%h tape_addr=%h want 0", {ram_we, dma_active, patch_sel, load_done}, ram_addr, tape_addr);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk_sys);
    tests_run++;
    if (wr_count - base !== 3) begin
      tests_failed++;
      $display("[TB] FAIL midreset_count: got %0d writes want 3", wr_count - base);
    end
  endtask

  task automatic test_restart;
    int base;
    int n;
    for (int i = 0; i < 10; i++) tape_mem[i] = 8'h60 + 8'(i);
    zx81 = 1'b1; tape_size = 14'd10; tape_type = 1'b1;
    base = wr_count;
    do_fetch(16'h0347);
    for (int k = 0; k < 300 && wr_count < base + 5; k++) @(negedge clk_sys);
    do_fetch(16'h0347);
    n = wr_count;
    tests_run++;
    if (load_done !== 1'b0 || dma_active !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_state: done=%b act=%b want 0/1", load_done, dma_active);
    end
    for (int k = 0; k < 100 && wr_count < n + 1; k++) @(negedge clk_sys);
    tests_run++;
    if (wr_count < n + 1 || wr_addr_log[n] !== 16'h4009 || wr_data_log[n] !== 8'h60) begin
      tests_failed++;
      $display("[TB] FAIL restart_first: got %h<=%h want 4009<=60", wr_addr_log[n], wr_data_log[n]);
    end
    for (int k = 0; k < 300 && !load_done; k++) @(negedge clk_sys);
    tests_run++;
    if (load_done !== 1'b1 || wr_count - n !== 10) begin
      tests_failed++;
      $display("[TB] FAIL restart_total: done=%b writes=%0d want 1/10", load_done, wr_count - n);
    end
    do_fetch(16'h0000);
  endtask

`ifdef TAPE_DMA_XSUM_EN
  task automatic test_xsum;
    tape_mem[0] = 8'h0F; tape_mem[1] = 8'hF0; tape_mem[2] = 8'hAA;
    zx81 = 1'b1; tape_size = 14'd3; tape_type = 1'b0;
    do_fetch(16'h0347);
    for (int k = 0; k < 300 && !load_done; k++) @(negedge clk_sys);
    repeat (8) @(negedge clk_sys);
    tests_run++;
    if (xsum !== 8'h55) begin
      tests_failed++;
      $display("[TB] FAIL xsum_done: got %h want 55", xsum);
    end
    do_fetch(16'h0000);
    tests_run++;
    if (xsum !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL xsum_idle: got %h want 00", xsum);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) tape_mem[i] = 8'h00;
    test_reset();
    test_zx81_p();
    test_zx80_o();
    test_empty();
    test_reset_mid();
    test_restart();
`ifdef TAPE_DMA_XSUM_EN
    test_xsum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
